// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding/hazard control slice: operand-select codes
// and the shadow pipeline entry that tracks in-flight destinations.
package fwd_hazard_ctrl_pkg;

   localparam int RA_W = 5;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_WB  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
   } shadow_t;

   // An entry only produces a forwardable value if it really writes a non-x0 register.
   function automatic logic live(input shadow_t e);
      return e.valid & e.reg_write & (e.rd != '0);
   endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Compares one ID source index against the EX and MEM shadow entries and
// returns the EX operand-mux select for that source.
module fwd_sel_cmp
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [RA_W-1:0] rs,
   input  logic            use_rs,
   input  shadow_t         ex_e,
   input  shadow_t         mem_e,
   output logic [1:0]      sel
);

   always_comb begin
      sel = SEL_REG;
      // A load in EX has no data yet; that case is covered by the stall, not here.
      if (use_rs && live(ex_e) && !ex_e.mem_read && (ex_e.rd == rs))
         sel = SEL_MEM;
      else if (use_rs && live(mem_e) && (mem_e.rd == rs))
         sel = SEL_WB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selects and load-use stall, driven from shadow copies
// of the EX/MEM destination fields fed from ID.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = RA_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_cnt
);

   shadow_t          ex_q, ex_d, mem_q, mem_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [1:0]       sel_a, sel_b;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_rs1, hit_rs2;

   fwd_sel_cmp u_cmp_a (.rs(id_rs1), .use_rs(id_use_rs1), .ex_e(ex_q), .mem_e(mem_q), .sel(sel_a));
   fwd_sel_cmp u_cmp_b (.rs(id_rs2), .use_rs(id_use_rs2), .ex_e(ex_q), .mem_e(mem_q), .sel(sel_b));

   assign hit_rs1 = id_use_rs1 & (ex_q.rd == id_rs1);
   assign hit_rs2 = id_use_rs2 & (ex_q.rd == id_rs2);
   assign stall   = id_valid & ~flush & live(ex_q) & ex_q.mem_read & (hit_rs1 | hit_rs2);

   always_comb begin
      mem_d   = ex_q;
      ex_d    = '0;
      fwd_a_d = SEL_REG;
      fwd_b_d = SEL_REG;
      if (!flush && !stall) begin
         ex_d = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
         if (id_valid) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
         end
      end
      cnt_d = cnt_q;
      if (stall && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         fwd_a_q <= SEL_REG;
         fwd_b_q <= SEL_REG;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding distances, load-use stall,
// x0 handling, flush priority, async reset and counter saturation.
module tb_fwd_hazard_ctrl;

   localparam int CNT_W = 8;

   logic             clk, rst_n;
   logic             id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic [1:0]       fwd_a, fwd_b;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive an ID instruction; combinational outputs are settled 2ns later.
   task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic fl);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int nstall;
   int budget;

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_fwd_a", fwd_a, 2'b00);
      chk("rst_fwd_b", fwd_b, 2'b00);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_stall", stall, 0);
      rst_n = 1'b1;
      tick();

      // ADD x5 then immediate reader of x5 on rs1
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);  tick();
      drv(1, 5, 1, 3, 1, 6, 1, 0, 0);
      chk("t1_stall", stall, 0);
      tick();
      chk("t1_fwd_a", fwd_a, 2'b10);
      chk("t1_fwd_b", fwd_b, 2'b00);

      // x5 written, unrelated instr, reader on rs2 -> WB forward
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);  tick();
      drv(1, 1, 1, 2, 1, 8, 1, 0, 0);  tick();
      drv(1, 9, 1, 5, 1, 10, 1, 0, 0); tick();
      chk("t2_fwd_b_wb", fwd_b, 2'b01);
      chk("t2_fwd_a", fwd_a, 2'b00);
      // x5 in both EX and MEM -> newest (EX) wins
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);  tick();
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);  tick();
      drv(1, 9, 1, 5, 1, 10, 1, 0, 0); tick();
      chk("t2_fwd_b_ex", fwd_b, 2'b10);
      // unused source never forwards
      drv(1, 10, 0, 10, 0, 11, 1, 0, 0); tick();
      chk("t2_unused_a", fwd_a, 2'b00);
      chk("t2_unused_b", fwd_b, 2'b00);

      // LW x7 then reader rs1=x7 -> one stall cycle, then WB forward
      drv(1, 1, 1, 0, 0, 7, 1, 1, 0);  tick();
      drv(1, 7, 1, 2, 1, 12, 1, 0, 0);
      chk("t3_stall", stall, 1);
      chk("t3_cnt0", stall_cnt, 0);
      tick();
      chk("t3_cnt1", stall_cnt, 1);
      chk("t3_bubble_a", fwd_a, 2'b00);
      #2;
      chk("t3_stall_rel", stall, 0);
      tick();
      chk("t3_fwd_a", fwd_a, 2'b01);
      chk("t3_cnt_hold", stall_cnt, 1);

      // x0 destination: never forwards, load to x0 never stalls
      drv(1, 1, 1, 0, 0, 0, 1, 1, 0);  tick();
      drv(1, 0, 1, 0, 1, 13, 1, 0, 0);
      chk("t4_stall", stall, 0);
      tick();
      chk("t4_fwd_a", fwd_a, 2'b00);
      chk("t4_fwd_b", fwd_b, 2'b00);

      // id_valid=0 enters EX as invalid; selects 00 even on a matching source
      drv(0, 13, 1, 0, 0, 14, 1, 0, 0); tick();
      chk("t4_inv_a", fwd_a, 2'b00);
      drv(1, 14, 1, 0, 0, 15, 1, 0, 0); tick();
      chk("t4_inv_fwd", fwd_a, 2'b00);

      // LW x7 + dependant with flush -> no stall, selects 00, EX bubble
      drv(1, 1, 1, 0, 0, 7, 1, 1, 0);  tick();
      drv(1, 7, 1, 7, 1, 16, 1, 0, 1);
      chk("t5_flush_stall", stall, 0);
      tick();
      chk("t5_flush_a", fwd_a, 2'b00);
      chk("t5_flush_b", fwd_b, 2'b00);
      chk("t5_flush_cnt", stall_cnt, 1);
      drv(1, 7, 1, 0, 0, 17, 1, 0, 0);
      chk("t5_post_stall", stall, 0);
      tick();
      chk("t5_post_a", fwd_a, 2'b01);

      // async reset in the middle of a load-use stall
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);  tick();
      drv(1, 5, 1, 0, 0, 7, 1, 1, 0);  tick();
      chk("t5_pre_a", fwd_a, 2'b10);
      drv(1, 7, 1, 0, 0, 18, 1, 0, 0);
      chk("t5_pre_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_stall", stall, 0);
      chk("t5_rst_a", fwd_a, 2'b00);
      chk("t5_rst_cnt", stall_cnt, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // saturating counter: a self-dependent load stalls every other cycle
      drv(1, 7, 1, 0, 0, 7, 1, 1, 0);
      nstall = 0;
      budget = 0;
      while (nstall < (1 << CNT_W) + 3 && budget < 2000) begin
         if (stall) nstall++;
         tick();
         #1;
         budget++;
         if (nstall == 3 && stall == 1'b0)
            ;
      end
      chk("t5_sat_budget", (nstall == (1 << CNT_W) + 3), 1);
      chk("t5_sat_cnt", stall_cnt, (1 << CNT_W) - 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("t5_sat_hold", stall_cnt, (1 << CNT_W) - 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
